// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NUM_REQ producers, with burst lock.
// Define FIFO_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    output logic                          fifo_wr_en,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_overflow,
    output logic                          busy,
    output logic                          overflow_seen
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   rr_ptr;
    logic [3:0]      beat_cnt;

    logic            block;
    logic            cap;
    logic            owner_ok;
    logic            scan_vld;
    logic [IW-1:0]   scan_idx;
    logic [IW-1:0]   scan_start;
    logic [IW-1:0]   cand;
    logic            win_vld;
    logic [IW-1:0]   win;
    logic [FIFO_WIDTH-1:0] win_data;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // A write already in flight consumes the last slot, so almostfull blocks only then.
    assign block = fifo_full | (fifo_almostfull & fifo_wr_en);
    assign cap   = (beat_cnt >= 4'(MAX_BURST));
    assign busy  = (state == BURST);

    assign owner_ok   = (state == BURST) && req[owner] && !cap;
    assign scan_start = (state == BURST) ? next_idx(owner) : rr_ptr;

    // During a burst the owner is excluded so a capped owner must pass through IDLE.
    always_comb begin
        scan_vld = 1'b0;
        scan_idx = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IW'((int'(scan_start) + k) % NUM_REQ);
            if (!scan_vld && req[cand] && !(state == BURST && cand == owner)) begin
                scan_vld = 1'b1;
                scan_idx = cand;
            end
        end
    end

    always_comb begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
        win_vld = (state == BURST) ? owner_ok : scan_vld;
`else
        win_vld = owner_ok | scan_vld;
`endif
        win = owner_ok ? owner : scan_idx;
        if (rst || block)
            win_vld = 1'b0;
        gnt = '0;
        if (win_vld)
            gnt[win] = 1'b1;
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (win == IW'(i))
                win_data = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wr_en    <= 1'b0;
            fifo_data_in  <= '0;
            overflow_seen <= 1'b0;
            state         <= IDLE;
            owner         <= '0;
            rr_ptr        <= '0;
            beat_cnt      <= '0;
        end else begin
            fifo_wr_en <= win_vld;
            if (win_vld)
                fifo_data_in <= win_data;
            if (fifo_overflow)
                overflow_seen <= 1'b1;

            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state    <= BURST;
                        owner    <= win;
                        beat_cnt <= 4'd1;
                    end
                end
                BURST: begin
                    if (win_vld) begin
                        if (win == owner) begin
                            if (beat_cnt != 4'hF)
                                beat_cnt <= beat_cnt + 4'd1;
                        end else begin
                            owner    <= win;
                            beat_cnt <= 4'd1;
`ifndef FIFO_ARB_FIXED_PRIO_EN
                            rr_ptr   <= next_idx(owner);
`endif
                        end
                    end else if (!req[owner] || cap) begin
                        state  <= IDLE;
`ifndef FIFO_ARB_FIXED_PRIO_EN
                        rr_ptr <= next_idx(owner);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
